// File: rtl/dkong3_audio_pkg.sv
// Shared constants and the output saturation helper for the DK3 audio conditioner.
package dkong3_audio_pkg;

  localparam int LPF_FRAC = 8;
  localparam int DC_W     = 20;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  localparam logic signed [DC_W-1:0] SAT_MAX_W = DC_W'(SAT_MAX);
  localparam logic signed [DC_W-1:0] SAT_MIN_W = DC_W'(SAT_MIN);

  typedef struct packed {
    logic [15:0] value;
    logic        clip;
  } sat_t;

  // Clamp the wide DC-block result to the 16-bit output range and flag when clamping happened.
  function automatic sat_t sat16(input logic signed [DC_W-1:0] y);
    sat_t r;
    r.value = y[15:0];
    r.clip  = 1'b0;
    if (y > SAT_MAX_W) begin
      r.value = SAT_MAX;
      r.clip  = 1'b1;
    end else if (y < SAT_MIN_W) begin
      r.value = SAT_MIN;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dkong3_dc_block.sv
// Stage 2: one-pole DC-blocking high-pass when DKONG3_AUDIO_DCBLOCK_EN is defined,
// otherwise a plain pipeline register so the output latency does not change.
module dkong3_dc_block import dkong3_audio_pkg::*; #(
  parameter int DC_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [15:0]            snap,
  output logic signed [DC_W-1:0] y,
  output logic                   out_valid
);

  logic signed [DC_W-1:0] snap_ext;
  logic signed [DC_W-1:0] y_reg;
  logic signed [DC_W-1:0] y_next;
  logic                   valid_reg;

  assign snap_ext = {{(DC_W-16){snap[15]}}, snap};

`ifdef DKONG3_AUDIO_DCBLOCK_EN
  logic signed [DC_W-1:0] snap_prev_reg;

  // y_reg doubles as y_prev: it holds the unsaturated result of the previous sample.
  always_comb begin
    y_next = snap_ext - snap_prev_reg + y_reg - (y_reg >>> DC_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_prev_reg <= '0;
    end else if (in_valid) begin
      snap_prev_reg <= snap_ext;
    end
  end
`else
  // The pole exponent has no effect when the DC block is compiled out.
  localparam int dc_shift_unused = DC_SHIFT;

  always_comb begin
    y_next = snap_ext;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        y_reg <= y_next;
      end
    end
  end

  assign y         = y_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/dkong3_audio_out.sv
// DK3 audio output conditioner: APU-rate low-pass, 48 kHz decimation, optional DC block
// (DKONG3_AUDIO_DCBLOCK_EN), saturation and mute.
module dkong3_audio_out import dkong3_audio_pkg::*; #(
  parameter int CLK_DIV   = 500,
  parameter int LPF_SHIFT = 2,
  parameter int DC_SHIFT  = 10
) (
  input  logic        I_CLK_24M,
  input  logic        I_RESETn,
  input  logic        I_SAMPLE_CE,
  input  logic [15:0] I_SAMPLE,
  input  logic        I_MUTE,
  output logic [15:0] O_SAMPLE,
  output logic        O_SAMPLE_VALID,
  output logic        O_CLIP
);

  localparam int LPF_W = 16 + LPF_FRAC;
  localparam int CNT_W = $clog2(CLK_DIV);

  logic signed [LPF_W-1:0] lpf_reg;
  logic signed [LPF_W-1:0] lpf_next;
  logic signed [LPF_W:0]   lpf_diff;
  logic signed [LPF_W:0]   lpf_step;

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  logic [15:0] snap_reg;
  logic        s1_valid_reg;

  logic signed [DC_W-1:0] dc_y;
  logic                   dc_valid;
  sat_t                   sat_res;

  logic [15:0] sample_reg;
  logic        valid_reg;
  logic        clip_reg;

  // The difference is formed one bit wider than the state so it can never wrap.
  always_comb begin
    lpf_diff = {I_SAMPLE[15], I_SAMPLE, {LPF_FRAC{1'b0}}} - {lpf_reg[LPF_W-1], lpf_reg};
    lpf_step = lpf_diff >>> LPF_SHIFT;
    lpf_next = LPF_W'({lpf_reg[LPF_W-1], lpf_reg} + lpf_step);
  end

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      lpf_reg <= '0;
    end else if (I_SAMPLE_CE) begin
      lpf_reg <= lpf_next;
    end
  end

  assign tick = (cnt_reg == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

  // Snapshot uses the pre-update filter value when a sample strobe lands on the tick.
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      snap_reg     <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= tick;
      if (tick) begin
        snap_reg <= lpf_reg[LPF_W-1:LPF_FRAC];
      end
    end
  end

  dkong3_dc_block #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk       (I_CLK_24M),
    .rst_n     (I_RESETn),
    .in_valid  (s1_valid_reg),
    .snap      (snap_reg),
    .y         (dc_y),
    .out_valid (dc_valid)
  );

  assign sat_res = sat16(dc_y);

  // Mute only gates the presented value; the clip flag still reflects the filter.
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sample_reg <= '0;
      valid_reg  <= 1'b0;
      clip_reg   <= 1'b0;
    end else begin
      valid_reg <= dc_valid;
      clip_reg  <= dc_valid & sat_res.clip;
      if (dc_valid) begin
        sample_reg <= I_MUTE ? 16'h0000 : sat_res.value;
      end
    end
  end

  assign O_SAMPLE       = sample_reg;
  assign O_SAMPLE_VALID = valid_reg;
  assign O_CLIP         = clip_reg;

endmodule

// File: tb/tb_dkong3_audio_out.sv
// Directed bench for dkong3_audio_out: reset cadence, steady tone, mute, saturation, mid-stream reset.
module tb_dkong3_audio_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        mute = 1'b0;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_clip;

  int n_checks = 0;
  int n_errors = 0;
  int ce_period = 0;
  int ce_phase = 0;
  int m_y = 0;
  int m_sp = 0;

  always #5 clk = ~clk;

  dkong3_audio_out dut (
    .I_CLK_24M      (clk),
    .I_RESETn       (rst_n),
    .I_SAMPLE_CE    (ce),
    .I_SAMPLE       (sample),
    .I_MUTE         (mute),
    .O_SAMPLE       (out_sample),
    .O_SAMPLE_VALID (out_valid),
    .O_CLIP         (out_clip)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Sample strobe generator: one CE every ce_period cycles, none when ce_period is 0.
  initial begin
    forever begin
      @(negedge clk);
      if (ce_period > 0 && ce_phase >= ce_period - 1) begin
        ce = 1'b1;
        ce_phase = 0;
      end else begin
        ce = 1'b0;
        ce_phase++;
      end
    end
  end

  // Counts negedges until a valid pulse is seen; n+1 is the edge at which a downstream
  // register would capture that valid.
  task automatic wait_valid(output int ncyc);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!out_valid && ncyc < 1000);
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  // Expected output for a given snapshot value, from the stage-2/3 arithmetic.
  task automatic model_step(input int snap, output int exp_s, output int exp_c);
`ifdef DKONG3_AUDIO_DCBLOCK_EN
    m_y  = snap - m_sp + m_y - (m_y >>> 10);
    m_sp = snap;
`else
    m_y = snap;
`endif
    if (m_y > 32767) begin
      exp_s = 'h7FFF; exp_c = 1;
    end else if (m_y < -32768) begin
      exp_s = 'h8000; exp_c = 1;
    end else begin
      exp_s = m_y & 'hFFFF; exp_c = 0;
    end
  endtask

  initial begin
    int n, es, ec;
    int clip_s[6];
    int clip_c[6];
`ifdef DKONG3_AUDIO_DCBLOCK_EN
    clip_s = '{'h7FFE, 'h8000, 'h8002, 'h7FFF, 'h7FFF, 'h7FE0};
    clip_c = '{0, 1, 0, 1, 1, 0};
`else
    clip_s = '{'h7FFE, 'h8000, 'h8000, 'h7FFE, 'h7FFE, 'h7FFE};
    clip_c = '{0, 0, 0, 0, 0, 0};
`endif

    // Reset and first-output cadence with a 0x1000 tone (settles to 0x0FFF).
    ce_period = 13;
    sample = 16'h1000;
    repeat (4) @(negedge clk);
    check("rst_sample", out_sample, 0);
    check("rst_valid", out_valid, 0);
    check("rst_clip", out_clip, 0);
    rst_n = 1'b1;
    wait_valid(n);
    check("first_valid_edge", n + 1, 503);
    model_step(4095, es, ec);
    check("tone1_sample", out_sample, es);
    check("tone1_clip", out_clip, ec);
    for (int i = 2; i <= 20; i++) begin
      wait_valid(n);
      if (i == 2) check("period", n, 500);
      model_step(4095, es, ec);
      check($sformatf("tone%0d_sample", i), out_sample, es);
      check($sformatf("tone%0d_clip", i), out_clip, ec);
    end

    // Mute during a 0x2000 tone, then release.
    sample = 16'h2000;
    mute = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      model_step(8191, es, ec);
      check($sformatf("mute%0d_sample", i), out_sample, 0);
      check($sformatf("mute%0d_clip", i), out_clip, ec);
    end
    mute = 1'b0;
    wait_valid(n);
    model_step(8191, es, ec);
    check("unmute_sample", out_sample, es);
    check("unmute_clip", out_clip, ec);

    // Full-scale steps for saturation.
    rst_n = 1'b0;
    #1;
    check("rst2_sample", out_sample, 0);
    sample = 16'h7FFF;
    ce_period = 4;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("rst2_first_valid_edge", n + 1, 503);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        if (k == 1) sample = 16'h8000;
        if (k == 3) sample = 16'h7FFF;
        wait_valid(n);
      end
      check($sformatf("step%0d_sample", k), out_sample, clip_s[k]);
      check($sformatf("step%0d_clip", k), out_clip, clip_c[k]);
    end

    // One-cycle reset one cycle after a tick: in-flight sample must be dropped.
    repeat (498) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sample", out_sample, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_clip", out_clip, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("midrst_first_valid_edge", n + 1, 503);
    check("midrst_sample_after", out_sample, 'h7FFE);
    check("midrst_clip_after", out_clip, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
